// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: shares the single bitmap video RAM port between video fetch and the CPU.
// Video wins during active display and the CPU wins during HBLANK/VBLANK. A CPU that has waited
// CPU_MAX_WAIT cycles wins the next arbitration outright. VID_LATE flags a video request that
// has waited VID_DEADLINE cycles.
// Optional feature macro: VRAM_ARB_STATS_EN (per-frame worst CPU wait on CPU_WAIT_MAX).
module vram_slot_arbiter #(
   parameter int unsigned ACC_CYCLES   = 2,
   parameter int unsigned CPU_MAX_WAIT = 6,
   parameter int unsigned VID_DEADLINE = 4
) (
   input  logic       CLK10,
   input  logic       RESETn,
   input  logic       HBLANK,
   input  logic       VBLANK,
   input  logic       VID_REQ,
   input  logic       CPU_REQ,
   input  logic       CPU_WE,
   output logic       VID_GNT,
   output logic       CPU_GNT,
   output logic       VID_ACK,
   output logic       CPU_ACK,
   output logic       RAM_WE,
   output logic       VID_LATE,
   output logic [7:0] CPU_WAIT_MAX
);

   localparam int unsigned   CW         = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CW-1:0] ACC_LAST   = CW'(ACC_CYCLES - 1);
   localparam logic [7:0]    CPU_MAX_W8 = 8'(CPU_MAX_WAIT);
   localparam logic [7:0]    VID_DL8    = 8'(VID_DEADLINE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_VGNT = 2'd1,
      S_CGNT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] acc_cnt_q, acc_cnt_d;
   logic          we_q, we_d;
   logic [7:0]    cpu_wait_q;
   logic [7:0]    vid_wait_q;
   logic          late_done_q;
   logic          vid_late_q;
   logic          late_fire;
   logic          blank;
   logic          acc_last;
   logic          cpu_starved;
   logic          pick_cpu;
   logic          pick_vid;
   logic          cpu_wait_clr;
   logic          vid_wait_clr;

   assign blank        = HBLANK | VBLANK;
   assign acc_last     = (acc_cnt_q == ACC_LAST);
   assign cpu_starved  = CPU_REQ & (cpu_wait_q >= CPU_MAX_W8);
   assign cpu_wait_clr = CPU_GNT | ~CPU_REQ;
   assign vid_wait_clr = VID_GNT | ~VID_REQ;
   assign late_fire    = ~late_done_q & (vid_wait_q == VID_DL8);
   assign VID_LATE     = vid_late_q;

   // State register, grant length counter and latched CPU write qualifier
   always_ff @(posedge CLK10 or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= S_IDLE;
         acc_cnt_q <= '0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_cnt_q <= acc_cnt_d;
         we_q      <= we_d;
      end
   end

   // IDLE priority: starved CPU first, then CPU in blanking, otherwise video first
   always_comb begin
      pick_cpu = 1'b0;
      pick_vid = 1'b0;
      if (cpu_starved) begin
         pick_cpu = 1'b1;
      end else if (blank) begin
         if (CPU_REQ)      pick_cpu = 1'b1;
         else if (VID_REQ) pick_vid = 1'b1;
      end else begin
         if (VID_REQ)      pick_vid = 1'b1;
         else if (CPU_REQ) pick_cpu = 1'b1;
      end
   end

   // Next-state and grant/ack decode; a grant always runs to its ACK and returns to IDLE
   always_comb begin
      state_d   = state_q;
      acc_cnt_d = '0;
      we_d      = we_q;
      VID_GNT   = 1'b0;
      CPU_GNT   = 1'b0;
      VID_ACK   = 1'b0;
      CPU_ACK   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_cpu) begin
               state_d = S_CGNT;
               we_d    = CPU_WE;
            end else if (pick_vid) begin
               state_d = S_VGNT;
            end
         end
         S_VGNT: begin
            VID_GNT = 1'b1;
            VID_ACK = acc_last;
            if (acc_last) state_d = S_IDLE;
            else          acc_cnt_d = acc_cnt_q + 1'b1;
         end
         S_CGNT: begin
            CPU_GNT = 1'b1;
            CPU_ACK = acc_last;
            if (acc_last) state_d = S_IDLE;
            else          acc_cnt_d = acc_cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      RAM_WE = CPU_GNT & we_q;
   end

   // Saturating wait counters, cleared while granted or not requesting
   always_ff @(posedge CLK10 or negedge RESETn) begin
      if (!RESETn) begin
         cpu_wait_q <= '0;
         vid_wait_q <= '0;
      end else begin
         if (cpu_wait_clr)              cpu_wait_q <= '0;
         else if (cpu_wait_q != 8'hFF)  cpu_wait_q <= cpu_wait_q + 8'd1;
         if (vid_wait_clr)              vid_wait_q <= '0;
         else if (vid_wait_q != 8'hFF)  vid_wait_q <= vid_wait_q + 8'd1;
      end
   end

   // One VID_LATE pulse per request; the flag re-arms whenever vid_wait clears
   always_ff @(posedge CLK10 or negedge RESETn) begin
      if (!RESETn) begin
         late_done_q <= 1'b0;
         vid_late_q  <= 1'b0;
      end else begin
         vid_late_q <= late_fire;
         if (vid_wait_clr)   late_done_q <= 1'b0;
         else if (late_fire) late_done_q <= 1'b1;
      end
   end

`ifdef VRAM_ARB_STATS_EN
   logic       vblank_q;
   logic       vblank_rise;
   logic [7:0] run_max_q;
   logic [7:0] cpu_wait_max_q;

   assign vblank_rise  = VBLANK & ~vblank_q;
   assign CPU_WAIT_MAX = cpu_wait_max_q;

   // Per-frame running max of cpu_wait; snapshot and restart on VBLANK rising edge
   always_ff @(posedge CLK10 or negedge RESETn) begin
      if (!RESETn) begin
         vblank_q       <= 1'b0;
         run_max_q      <= '0;
         cpu_wait_max_q <= '0;
      end else begin
         vblank_q <= VBLANK;
         if (vblank_rise) begin
            cpu_wait_max_q <= run_max_q;
            // a wait that beats the old max in the snapshot cycle seeds the new frame
            run_max_q      <= (cpu_wait_q > run_max_q) ? cpu_wait_q : '0;
         end else if (cpu_wait_q > run_max_q) begin
            run_max_q <= cpu_wait_q;
         end
      end
   end
`else
   assign CPU_WAIT_MAX = '0;
`endif

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: directed scoreboard bench for vram_slot_arbiter.
// dut_a uses ACC_CYCLES=2, dut_b uses ACC_CYCLES=8; both CPU_MAX_WAIT=6, VID_DEADLINE=4.
// Expected ACK/VID_LATE events are queued by the stimulus and checked by a negedge monitor.
module tb_vram_slot_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic a_hb, a_vb, a_vreq, a_creq, a_we;
   logic b_hb, b_vb, b_vreq, b_creq, b_we;
   logic [1:0] vgnt, cgnt, vack, cack, rwe, late;
   logic [7:0] wmax_a, wmax_b;

   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;

   typedef struct {
      int unsigned d;
      int unsigned kind;   // 0 video ack, 1 cpu ack, 2 vid_late
      int unsigned start;
      int unsigned at;
      logic        we;
   } exp_t;

   exp_t exp_q[$];
   int unsigned vstart[2];
   int unsigned cstart[2];
   logic [1:0]  vgnt_prev = '0;
   logic [1:0]  cgnt_prev = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vram_slot_arbiter #(.ACC_CYCLES(2), .CPU_MAX_WAIT(6), .VID_DEADLINE(4)) dut_a (
      .CLK10(clk), .RESETn(rst_n), .HBLANK(a_hb), .VBLANK(a_vb),
      .VID_REQ(a_vreq), .CPU_REQ(a_creq), .CPU_WE(a_we),
      .VID_GNT(vgnt[0]), .CPU_GNT(cgnt[0]), .VID_ACK(vack[0]), .CPU_ACK(cack[0]),
      .RAM_WE(rwe[0]), .VID_LATE(late[0]), .CPU_WAIT_MAX(wmax_a)
   );

   vram_slot_arbiter #(.ACC_CYCLES(8), .CPU_MAX_WAIT(6), .VID_DEADLINE(4)) dut_b (
      .CLK10(clk), .RESETn(rst_n), .HBLANK(b_hb), .VBLANK(b_vb),
      .VID_REQ(b_vreq), .CPU_REQ(b_creq), .CPU_WE(b_we),
      .VID_GNT(vgnt[1]), .CPU_GNT(cgnt[1]), .VID_ACK(vack[1]), .CPU_ACK(cack[1]),
      .RAM_WE(rwe[1]), .VID_LATE(late[1]), .CPU_WAIT_MAX(wmax_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int unsigned d, input int unsigned kind, input int unsigned start,
                       input int unsigned at, input logic we);
      exp_t e;
      e.d = d; e.kind = kind; e.start = start; e.at = at; e.we = we;
      exp_q.push_back(e);
   endtask

   task automatic mon_pop(input int unsigned d, input int unsigned kind, input int unsigned start,
                          input logic we);
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event actual dut=%0d kind=%0d cyc=%0d required=none", d, kind, cyc);
         return;
      end
      e = exp_q.pop_front();
      if (e.d != d || e.kind != kind || e.at != cyc ||
          (kind != 2 && e.start != start) || (kind == 1 && e.we !== we)) begin
         bad++;
         $display("FAIL event actual dut=%0d kind=%0d start=%0d cyc=%0d we=%0b required dut=%0d kind=%0d start=%0d cyc=%0d we=%0b",
                  d, kind, start, cyc, we, e.d, e.kind, e.start, e.at, e.we);
      end
   endtask

   // Monitor: track grant starts, check exclusivity, pop expected events on ACK/VID_LATE
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (vgnt[d] && !vgnt_prev[d]) vstart[d] = cyc;
         if (cgnt[d] && !cgnt_prev[d]) cstart[d] = cyc;
         if (vgnt[d] || cgnt[d]) chk("gnt_exclusive", 32'(vgnt[d] & cgnt[d]), 32'd0);
         if (vack[d]) mon_pop(d, 0, vstart[d], 1'b0);
         if (cack[d]) mon_pop(d, 1, cstart[d], rwe[d]);
         if (late[d]) mon_pop(d, 2, 0, 1'b0);
         vgnt_prev[d] = vgnt[d];
         cgnt_prev[d] = cgnt[d];
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int unsigned t0;
      rst_n = 1'b0;
      a_hb = 0; a_vb = 0; a_vreq = 0; a_creq = 0; a_we = 0;
      b_hb = 0; b_vb = 0; b_vreq = 0; b_creq = 0; b_we = 0;
      #3;
      chk("reset_outputs_a", 32'({vgnt[0], cgnt[0], vack[0], cack[0], rwe[0], late[0], wmax_a}), 32'd0);
      chk("reset_outputs_b", 32'({vgnt[1], cgnt[1], vack[1], cack[1], rwe[1], late[1], wmax_b}), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // reset in the middle of a video grant: no ACK, everything drops at once
      a_vreq = 1;
      tick(1);
      chk("mid_grant_vid_gnt", 32'(vgnt[0]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({vgnt[0], cgnt[0], vack[0], cack[0], rwe[0], late[0]}), 32'd0);
      a_vreq = 0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("post_reset_idle", 32'({vgnt[0], cgnt[0], vack[0], cack[0], rwe[0], late[0]}), 32'd0);

      // active display, both request: video first, then CPU (write)
      t0 = cyc;
      a_vreq = 1; a_creq = 1; a_we = 1;
      push(0, 0, t0 + 1, t0 + 2, 1'b0);
      push(0, 1, t0 + 4, t0 + 5, 1'b1);
      tick(3); a_vreq = 0;
      tick(3); a_creq = 0; a_we = 0;
      tick(4);

      // HBLANK: CPU first (read), then video; video waited 4 cycles -> VID_LATE
      t0 = cyc;
      a_hb = 1; a_vreq = 1; a_creq = 1; a_we = 0;
      push(0, 1, t0 + 1, t0 + 2, 1'b0);
      push(0, 0, t0 + 4, t0 + 5, 1'b0);
      push(0, 2, 0, t0 + 5, 1'b0);
      tick(3); a_creq = 0;
      tick(3); a_vreq = 0; a_hb = 0;
      tick(4);

      // CPU starvation guard: video wins twice, CPU forced at cpu_wait=6
      t0 = cyc;
      a_vreq = 1; a_creq = 1; a_we = 1;
      push(0, 0, t0 + 1, t0 + 2, 1'b0);
      push(0, 0, t0 + 4, t0 + 5, 1'b0);
      push(0, 1, t0 + 7, t0 + 8, 1'b1);
      push(0, 0, t0 + 10, t0 + 11, 1'b0);
      push(0, 2, 0, t0 + 11, 1'b0);
      tick(9); a_creq = 0; a_we = 0;
      tick(3); a_vreq = 0;
      tick(4);

      // ACC_CYCLES=8: video request during a long CPU grant hits its deadline once
      t0 = cyc;
      b_creq = 1; b_we = 1;
      tick(1); b_vreq = 1;
      push(1, 2, 0, t0 + 6, 1'b0);
      push(1, 1, t0 + 1, t0 + 8, 1'b1);
      push(1, 0, t0 + 10, t0 + 17, 1'b0);
      tick(8); b_creq = 0; b_we = 0;
      tick(9); b_vreq = 0;
      tick(4);

      // worst CPU wait of 9 in the frame, then VBLANK rises
      t0 = cyc;
      b_vreq = 1;
      tick(1); b_creq = 1; b_we = 0;
      push(1, 0, t0 + 1, t0 + 8, 1'b0);
      push(1, 1, t0 + 10, t0 + 17, 1'b0);
      tick(8); b_vreq = 0;
      tick(9); b_creq = 0;
      tick(3);
      chk("wait_max_before_vblank", 32'(wmax_b), 32'd0);
      b_vb = 1;
      tick(1);
`ifdef VRAM_ARB_STATS_EN
      chk("wait_max_after_vblank", 32'(wmax_b), 32'd9);
`else
      chk("wait_max_after_vblank", 32'(wmax_b), 32'd0);
`endif
      tick(2);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
      chk("pending_events", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
